// File: rtl/io_display_pkg.sv
// rtl/io_display_pkg.sv - shared types and constants for the hex display controller
package io_display_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_STORE
    } state_t;

    localparam int NUM_CH    = 3;
    localparam int CONV_BITS = 7;
    localparam int CLAMP_MAX = 99;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to active-low 7-segment decoder
module seg7_decode
    import io_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Nibbles above 9 never come out of the converter; show them blank
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/io_hex_display.sv
// rtl/io_hex_display.sv - round-robin clamped double-dabble driver for six 7-segment digits
module io_hex_display
    import io_display_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value0,
    input  logic [31:0] value1,
    input  logic [31:0] value2,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        led0,
    output logic        led1,
    output logic        led2,
    output logic        frame_done
);

    state_t               state;
    state_t               state_next;
    logic [1:0]           ch;
    logic [CONV_BITS-1:0] bin;
    logic [7:0]           bcd;
    logic [7:0]           bcd_adj;
    logic [2:0]           cnt;
    logic                 ovf_pending;
    logic [31:0]          sample;
    logic [6:0]           seg_tens_raw;
    logic [6:0]           seg_tens;
    logic [6:0]           seg_ones;

    // Pick the port belonging to the channel about to be loaded
    always_comb begin
        sample = value0;
        case (ch)
            2'd1:    sample = value1;
            2'd2:    sample = value2;
            default: sample = value0;
        endcase
    end

    // Add-3 correction on each BCD nibble ahead of the shift
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
    end

    seg7_decode u_tens (.digit(bcd[7:4]), .seg(seg_tens_raw));
    seg7_decode u_ones (.digit(bcd[3:0]), .seg(seg_ones));

    // Leading-zero blanking only affects the tens digit
    always_comb begin
        seg_tens = seg_tens_raw;
        if (BLANK_LZ && (bcd[7:4] == 4'd0)) seg_tens = SEG_BLANK;
    end

    // Next-state logic: one load, CONV_BITS shifts, one store
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:  state_next = S_SHIFT;
            S_SHIFT: if (cnt == 3'(CONV_BITS - 1)) state_next = S_STORE;
            S_STORE: state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_LOAD;
        else       state <= state_next;
    end

    // Conversion datapath and registered display outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            ch          <= 2'd0;
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            hex0        <= SEG_BLANK;
            hex1        <= SEG_BLANK;
            hex2        <= SEG_BLANK;
            hex3        <= SEG_BLANK;
            hex4        <= SEG_BLANK;
            hex5        <= SEG_BLANK;
            led0        <= 1'b0;
            led1        <= 1'b0;
            led2        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_LOAD: begin
                    // Full-width compare so large values never wrap into range
                    if (sample > 32'(CLAMP_MAX)) begin
                        bin         <= CONV_BITS'(CLAMP_MAX);
                        ovf_pending <= 1'b1;
                    end else begin
                        bin         <= sample[CONV_BITS-1:0];
                        ovf_pending <= 1'b0;
                    end
                    bcd <= '0;
                    cnt <= '0;
                end
                S_SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 3'd1;
                end
                S_STORE: begin
                    case (ch)
                        2'd0: begin
                            hex0 <= seg_ones;
                            hex1 <= seg_tens;
                            led0 <= ovf_pending;
                        end
                        2'd1: begin
                            hex2 <= seg_ones;
                            hex3 <= seg_tens;
                            led1 <= ovf_pending;
                        end
                        default: begin
                            hex4 <= seg_ones;
                            hex5 <= seg_tens;
                            led2 <= ovf_pending;
                        end
                    endcase
                    frame_done <= (ch == 2'(NUM_CH - 1));
                    ch         <= (ch == 2'(NUM_CH - 1)) ? 2'd0 : ch + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_hex_display.sv
// tb/tb_io_hex_display.sv - directed self-checking bench for io_hex_display
module tb_io_hex_display;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] value0 = '0, value1 = '0, value2 = '0;
    logic [6:0]  h0, h1, h2, h3, h4, h5;
    logic        l0, l1, l2, fd;
    logic [6:0]  z0, z1, z2, z3, z4, z5;
    logic        zl0, zl1, zl2, zfd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_hex_display #(.BLANK_LZ(1'b1)) dut (
        .clock(clk), .reset(reset), .value0(value0), .value1(value1), .value2(value2),
        .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .hex4(h4), .hex5(h5),
        .led0(l0), .led1(l1), .led2(l2), .frame_done(fd)
    );

    io_hex_display #(.BLANK_LZ(1'b0)) dut_nz (
        .clock(clk), .reset(reset), .value0(value0), .value1(value1), .value2(value2),
        .hex0(z0), .hex1(z1), .hex2(z2), .hex3(z3), .hex4(z4), .hex5(z5),
        .led0(zl0), .led1(zl1), .led2(zl2), .frame_done(zfd)
    );

    // Wait (bounded) for the next frame_done pulse of the blanking instance
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd && n < 60);
        checks++;
        if (!fd) begin
            errors++;
            $display("FAIL frame_timeout: frame_done not seen within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        value0 = 32'd55; value1 = 32'd123; value2 = 32'd9;
        repeat (3) @(negedge clk);
        checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {6{B}}) begin
            errors++;
            $display("FAIL reset_hex: got %h expected %h", {h5, h4, h3, h2, h1, h0}, {6{B}});
        end
        checks++;
        if ({l2, l1, l0, fd} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_led_fd: got %b expected 0000", {l2, l1, l0, fd});
        end
        reset = 1'b0;
        wait_frame(n);
        checks++;
        if (n != 27) begin
            errors++;
            $display("FAIL reset_first_frame: got %0d cycles expected 27", n);
        end
    endtask

    task automatic test_basic();
        int n;
        value0 = 32'd42; value1 = 32'd7; value2 = 32'd0;
        wait_frame(n);
        wait_frame(n);
        checks++;
        if ({h1, h0} !== {D4, D2}) begin
            errors++;
            $display("FAIL basic_ch0: got %b_%b expected %b_%b", h1, h0, D4, D2);
        end
        checks++;
        if ({h3, h2} !== {B, D7}) begin
            errors++;
            $display("FAIL basic_ch1: got %b_%b expected %b_%b", h3, h2, B, D7);
        end
        checks++;
        if ({h5, h4} !== {B, D0}) begin
            errors++;
            $display("FAIL basic_ch2: got %b_%b expected %b_%b", h5, h4, B, D0);
        end
        checks++;
        if ({l2, l1, l0} !== 3'b000) begin
            errors++;
            $display("FAIL basic_led: got %b expected 000", {l2, l1, l0});
        end
    endtask

    task automatic test_clamp();
        int n;
        logic [31:0] vals [4] = '{32'd99, 32'd100, 32'hFFFFFFFF, 32'h00000080};
        logic        leds [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            value2 = vals[i];
            wait_frame(n);
            wait_frame(n);
            checks++;
            if ({h5, h4} !== {D9, D9}) begin
                errors++;
                $display("FAIL clamp_hex[%0d]: got %b_%b expected %b_%b", i, h5, h4, D9, D9);
            end
            checks++;
            if (l2 !== leds[i]) begin
                errors++;
                $display("FAIL clamp_led[%0d]: got %b expected %b", i, l2, leds[i]);
            end
        end
    endtask

    task automatic test_mid_change();
        int n;
        value0 = 32'd42; value1 = 32'd12; value2 = 32'd0;
        wait_frame(n);
        wait_frame(n);
        // Cycle 11 of the frame falls inside channel 1's shift phase
        repeat (11) @(negedge clk);
        value1 = 32'd55;
        wait_frame(n);
        checks++;
        if ({h3, h2} !== {D1, D2}) begin
            errors++;
            $display("FAIL mid_current: got %b_%b expected %b_%b", h3, h2, D1, D2);
        end
        wait_frame(n);
        checks++;
        if ({h3, h2} !== {D5, D5}) begin
            errors++;
            $display("FAIL mid_next: got %b_%b expected %b_%b", h3, h2, D5, D5);
        end
        checks++;
        if ({h5, h4, h1, h0, l2, l1, l0} !== {B, D0, D4, D2, 3'b000}) begin
            errors++;
            $display("FAIL mid_others: got %h expected %h",
                     {h5, h4, h1, h0, l2, l1, l0}, {B, D0, D4, D2, 3'b000});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_frame(n);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({h5, h4, h3, h2, h1, h0, l2, l1, l0, fd} !== {{6{B}}, 4'b0000}) begin
            errors++;
            $display("FAIL rstmid_blank: got %h expected %h",
                     {h5, h4, h3, h2, h1, h0, l2, l1, l0, fd}, {{6{B}}, 4'b0000});
        end
        reset = 1'b0;
        wait_frame(n);
        checks++;
        if (n != 27) begin
            errors++;
            $display("FAIL rstmid_frame: got %0d cycles expected 27", n);
        end
        checks++;
        if ({h5, h4, h3, h2, h1, h0} !== {B, D0, D5, D5, D4, D2}) begin
            errors++;
            $display("FAIL rstmid_restore: got %h expected %h",
                     {h5, h4, h3, h2, h1, h0}, {B, D0, D5, D5, D4, D2});
        end
    endtask

    task automatic test_no_blank();
        int n;
        value0 = 32'd5;
        wait_frame(n);
        wait_frame(n);
        checks++;
        if ({z1, z0} !== {D0, D5}) begin
            errors++;
            $display("FAIL nz_ch0: got %b_%b expected %b_%b", z1, z0, D0, D5);
        end
        checks++;
        if ({z5, z4, z3, z2, zl2, zl1, zl0} !== {D0, D0, D5, D5, 3'b000}) begin
            errors++;
            $display("FAIL nz_others: got %h expected %h",
                     {z5, z4, z3, z2, zl2, zl1, zl0}, {D0, D0, D5, D5, 3'b000});
        end
        checks++;
        if ({h1, h0} !== {B, D5}) begin
            errors++;
            $display("FAIL lz_ch0: got %b_%b expected %b_%b", h1, h0, B, D5);
        end
        // Align to the no-blank instance's own pulse, then time 10 periods
        n = 0;
        while (!zfd && n < 60) begin
            @(negedge clk);
            n++;
        end
        for (int f = 0; f < 10; f++) begin
            @(negedge clk);
            checks++;
            if (zfd !== 1'b0) begin
                errors++;
                $display("FAIL nz_pulse_width[%0d]: got %b expected 0", f, zfd);
            end
            n = 1;
            while (!zfd && n < 60) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != 27) begin
                errors++;
                $display("FAIL nz_period[%0d]: got %0d expected 27", f, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_mid_change();
        test_reset_mid();
        test_no_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_hex_display.md
# io_hex_display

Sequential binary-to-decimal display controller that sits directly downstream of the single-cycle computer's I/O ports. It drives the six 7-segment digits and the overflow LEDs from three 32-bit port values. At top level these are in_port0, in_port1 and out_port0. Each value is clamped to 0..99, converted by one shared iterative shift-add-3 (double-dabble) engine in round-robin order, and latched into segment registers.

## Interface
- BLANK_LZ, 1, when 1 a zero tens digit is blanked; when 0 it shows "0"
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- value0  input  32  channel 0 value (tied to in_port0)
- value1  input  32  channel 1 value (tied to in_port1)
- value2  input  32  channel 2 value (tied to out_port0)
- hex0, hex1  output  7  channel 0 ones/tens segments, active-low, bit order {g,f,e,d,c,b,a}
- hex2, hex3  output  7  channel 1 ones/tens segments
- hex4, hex5  output  7  channel 2 ones/tens segments
- led0, led1, led2  output  1  channel 0/1/2 overflow flag (value > 99)
- frame_done  output  1  one-cycle pulse when channel 2's result is latched

## Operation
- FSM states are S_LOAD, S_SHIFT and S_STORE. A channel index ch cycles 0 → 1 → 2 → 0.
- **S_LOAD (1 cycle)**
  - Sample value[ch] into an internal register. Later changes to the input do not affect this conversion.
  - If the sample is > 99 (full 32-bit unsigned compare), load 7'd99 and set ovf_pending. Otherwise load sample[6:0] and clear ovf_pending.
  - Clear the 8-bit BCD accumulator and set the iteration counter to 0. Go to S_SHIFT.
- **S_SHIFT (7 cycles)**
  - Each cycle, add 3 to any BCD nibble that is ≥ 5.
  - Then shift {bcd, bin} left by 1.
  - Increment the counter. When the counter reaches 6, go to S_STORE.
- **S_STORE (1 cycle)**
  - Decode the tens and ones nibbles into the channel's segment registers and write the channel LED from ovf_pending.
  - Apply leading-zero blanking when BLANK_LZ=1 and tens==0: tens output = 7'b1111111. A value of 0 still shows "0" on the ones digit.
  - Pulse frame_done when ch==2. Advance ch and go to S_LOAD.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibbles above 9 cannot occur. The decoder maps them to blank (1111111).
- Only the channel being stored changes its outputs. The other channels hold their last values.

## Timing
- **Reset** (sampled on a rising clock edge, takes priority over everything):
  - hex0..hex5 = 7'b1111111 (blank), led0..2 = 0, frame_done = 0.
  - State = S_LOAD, ch = 0, accumulator and counter cleared.
- **Reset mid-conversion:** the conversion is aborted and all outputs are blanked, including previously latched channels. After reset releases, conversion restarts at channel 0.
- **Per-channel latency:** 9 cycles (1 load + 7 shift + 1 store). A value sampled at the S_LOAD edge of cycle t appears on the outputs after the edge of cycle t+8, i.e. visible from cycle t+9.
- **Frame period:** 27 cycles. frame_done is high for exactly 1 cycle in every 27. The first pulse is 27 cycles after reset deasserts.
- **Worst-case update latency:** an input change is visible within 35 cycles (just misses its S_LOAD, waits 26 cycles, then takes 9).
- **Input change during S_SHIFT/S_STORE:** no effect on the current conversion. The new value is picked up at that channel's next S_LOAD.
- **Boundaries:**
  - 99 → "99", LED = 0.
  - 100 → "99", LED = 1.
  - 32'hFFFFFFFF → "99", LED = 1. Clamping must not use only the low 7 bits.
  - 0 → tens blank (BLANK_LZ=1), ones "0".
- There are no combinational paths from inputs to outputs. All outputs are registered.

## Structure
- Package io_display_pkg holds:
  - the state enum {S_LOAD, S_SHIFT, S_STORE}
  - NUM_CH = 3, CONV_BITS = 7, CLAMP_MAX = 99, SEG_BLANK = 7'b1111111
  - the 10 segment-code constants
- Sub-module seg7_decode: combinational 4-bit digit to 7-bit active-low segments, with blank for values > 9.
- io_hex_display instantiates seg7_decode twice, for the tens and ones digits.

## Test plan
- **Reset:** hold reset 3 cycles with any inputs → all hex = 1111111, LEDs = 0, frame_done = 0. Release → first frame_done exactly 27 cycles later.
- **Basic conversion:** value0=42, value1=7, value2=0 → after the first frame:
  - hex1/hex0 = 0011001/0100100 ("42")
  - hex3/hex2 = 1111111/1111000 (" 7")
  - hex5/hex4 = 1111111/1000000 (" 0")
  - LEDs = 0
- **Clamping:** value2 = 99, then 100, then 32'hFFFFFFFF, then 32'h00000080 (128). Each case → hex5/hex4 = 0010000/0010000 ("99"). led2 = 0 for 99 and 1 for the other three.
- **Mid-conversion change:** change value1 from 12 to 55 during channel 1's S_SHIFT. Required response:
  - The current frame stores "12".
  - The next frame stores "55" (0010010/0010010).
  - Channels 0 and 2 are unchanged.
- **Reset mid-conversion:** assert reset during channel 0's S_SHIFT. All outputs blank on the next cycle, ch restarts at 0, and correct values are restored 27 cycles after release.
- **BLANK_LZ=0 instance:** value0 = 5 → hex1 = 1000000, hex0 = 0010010 ("05"). Confirm frame_done period is 27 across 10 consecutive frames.
